// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined CORDIC, rotation (sin/cos) and vectoring
// (magnitude/phase) selected per sample, full +/-pi coverage through a
// quadrant pre-rotation stage, valid/ready flow control with a sideband tag.
// Optional macro CORDIC_GAIN_COMP_EN adds a final stage that multiplies
// out_x/out_y by K so results come out unscaled (one extra cycle of latency).

// One micro-rotation: constant shift and constant angle, no state.
module cordic_stage #(
  parameter int                   W     = 34,
  parameter int                   SHIFT = 0,
  parameter logic signed [W-1:0]  ATAN  = '0
) (
  input  logic                mode,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  output logic signed [W-1:0] x_n,
  output logic signed [W-1:0] y_n,
  output logic signed [W-1:0] z_n
);
  logic signed [W-1:0] xs, ys;
  logic                d_pos;

  assign xs    = x >>> SHIFT;
  assign ys    = y >>> SHIFT;
  // rotation drives z toward 0, vectoring drives y toward 0
  assign d_pos = mode ? y[W-1] : !z[W-1];

  // Rotate by +/- atan(2^-SHIFT) depending on the direction bit.
  always_comb begin
    x_n = x;
    y_n = y;
    z_n = z;
    if (d_pos) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - ATAN;
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + ATAN;
    end
  end
endmodule

module cordic_pipe #(
  parameter int N      = 32,
  parameter int FRAC   = 29,
  parameter int STAGES = 16,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_y,
  input  logic [N-1:0]     in_z,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_x,
  output logic [N-1:0]     out_y,
  output logic [N-1:0]     out_z,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
);
  // two guard bits cover the ~1.65 gain plus the pre-rotation swap
  localparam int W = N + 2;

  // pi/4 with 62 fraction bits; every angle constant is derived from it
  localparam logic [63:0] PI4_Q62 = 64'h3243F6A8885A308D;

  // Round-to-nearest right shift of a Q62 constant.
  function automatic logic [63:0] rnd(input logic [63:0] v, input int sh);
    return (v + (64'd1 << (sh - 1))) >> sh;
  endfunction

  // atan(2^-i) in Q62 via its Taylor series (i >= 1); i = 0 is pi/4.
  function automatic logic [63:0] atan_q62(input int i);
    logic [63:0] acc, t;
    int          sh;
    if (i == 0) return PI4_Q62;
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      sh = 62 - i * (2 * k + 1);
      if (sh >= 0) begin
        t = (64'd1 << sh) / 64'(2 * k + 1);
        if (k % 2 == 0) acc = acc + t;
        else            acc = acc - t;
      end
    end
    return acc;
  endfunction

  function automatic logic [63:0] atan_frac(input int i);
    return rnd(atan_q62(i), 62 - FRAC);
  endfunction

  localparam logic signed [W-1:0] HALF_PI = W'(rnd(PI4_Q62, 61 - FRAC));

  // Clamp a W-bit intermediate into the N-bit output range.
  function automatic logic [N-1:0] sat(input logic [W-1:0] v);
    if ((&v[W-1:N-1]) || !(|v[W-1:N-1])) return v[N-1:0];
    else if (v[W-1])                      return {1'b1, {(N-1){1'b0}}};
    else                                  return {1'b0, {(N-1){1'b1}}};
  endfunction

  typedef struct packed {
    logic             mode;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [W-1:0]     z;
  } smp_t;

  logic                advance;
  logic [STAGES:0]     vld_pipe;
  smp_t                pipe [STAGES+1];
  smp_t                pre;
  logic signed [W-1:0] xi, yi, zi;
  logic signed [W-1:0] nx [STAGES];
  logic signed [W-1:0] ny [STAGES];
  logic signed [W-1:0] nz [STAGES];

  logic                fin_valid, fin_mode;
  logic [N-1:0]        fin_x, fin_y, fin_z;
  logic [TAG_W-1:0]    fin_tag;

  // the whole pipe moves together; a stalled output freezes everything
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign xi = {{2{in_x[N-1]}}, in_x};
  assign yi = {{2{in_y[N-1]}}, in_y};
  assign zi = {{2{in_z[N-1]}}, in_z};

  // Quadrant pre-rotation so the micro-rotations only see +/-pi/2.
  always_comb begin
    pre      = '0;
    pre.mode = in_mode;
    pre.tag  = in_tag;
    pre.x    = xi;
    pre.y    = yi;
    pre.z    = zi;
    if (!in_mode) begin
      if (zi > HALF_PI) begin
        pre.x = -yi;
        pre.y = xi;
        pre.z = zi - HALF_PI;
      end else if (zi < -HALF_PI) begin
        pre.x = yi;
        pre.y = -xi;
        pre.z = zi + HALF_PI;
      end
    end else begin
      pre.z = '0;
      if (xi[W-1]) begin
        if (!yi[W-1]) begin
          pre.x = yi;
          pre.y = -xi;
          pre.z = HALF_PI;
        end else begin
          pre.x = -yi;
          pre.y = xi;
          pre.z = -HALF_PI;
        end
      end
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(
      .W     (W),
      .SHIFT (i),
      .ATAN  (W'(atan_frac(i)))
    ) u_stage (
      .mode (pipe[i].mode),
      .x    (pipe[i].x),
      .y    (pipe[i].y),
      .z    (pipe[i].z),
      .x_n  (nx[i]),
      .y_n  (ny[i]),
      .z_n  (nz[i])
    );
  end

  // Stage 0 captures the pre-rotated input; stages 1..STAGES the micro-rotations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 0; s <= STAGES; s++) pipe[s] <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      pipe[0]  <= pre;
      for (int s = 1; s <= STAGES; s++) begin
        pipe[s].mode <= pipe[s-1].mode;
        pipe[s].tag  <= pipe[s-1].tag;
        pipe[s].x    <= nx[s-1];
        pipe[s].y    <= ny[s-1];
        pipe[s].z    <= nz[s-1];
      end
    end
  end

  // Final register: saturate back to N bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_valid <= 1'b0;
      fin_mode  <= 1'b0;
      fin_tag   <= '0;
      fin_x     <= '0;
      fin_y     <= '0;
      fin_z     <= '0;
    end else if (advance) begin
      fin_valid <= vld_pipe[STAGES];
      fin_mode  <= pipe[STAGES].mode;
      fin_tag   <= pipe[STAGES].tag;
      fin_x     <= sat(pipe[STAGES].x);
      fin_y     <= sat(pipe[STAGES].y);
      fin_z     <= sat(pipe[STAGES].z);
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  // K = 0.6072529350 rounded to FRAC bits
  localparam logic [N-1:0] K_Q =
    N'(((128'd6072529350 << FRAC) + 128'd5000000000) / 128'd10000000000);
  localparam logic signed [2*N:0] HALF_LSB = (2*N+1)'(1) << (FRAC - 1);

  // Multiply by K with round-to-nearest and saturation.
  function automatic logic [N-1:0] mulk(input logic [N-1:0] v);
    logic signed [2*N:0] p, r;
    p = $signed(v) * $signed({1'b0, K_Q});
    r = (p + HALF_LSB) >>> FRAC;
    if ((&r[2*N:N-1]) || !(|r[2*N:N-1])) return r[N-1:0];
    else if (r[2*N])                      return {1'b1, {(N-1){1'b0}}};
    else                                  return {1'b0, {(N-1){1'b1}}};
  endfunction

  // Gain-compensation register drives the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (advance) begin
      out_valid <= fin_valid;
      out_mode  <= fin_mode;
      out_tag   <= fin_tag;
      out_x     <= mulk(fin_x);
      out_y     <= mulk(fin_y);
      out_z     <= fin_z;
    end
  end
`else
  assign out_valid = fin_valid;
  assign out_mode  = fin_mode;
  assign out_tag   = fin_tag;
  assign out_x     = fin_x;
  assign out_y     = fin_y;
  assign out_z     = fin_z;
`endif

endmodule

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe: directed table (latency + values), a randomized
// stream with backpressure against a real-arithmetic model, and a mid-stream
// reset. Honors CORDIC_GAIN_COMP_EN for latency and output scaling.
module tb_cordic_pipe;
  localparam int N = 32, FRAC = 29, STAGES = 16, TAG_W = 4;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT = STAGES + 3;
  localparam real KC  = 0.6072529350;
`else
  localparam int  LAT = STAGES + 2;
  localparam real KC  = 1.0;
`endif
  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = 536870912.0;      // 2^FRAC
  localparam real VT    = 1.0 / 16384.0;    // 2^-14
  localparam real AT    = 1.0 / 8192.0;     // 2^-13
  localparam int  NS    = 200;

  logic             clk, rst;
  logic             in_valid, in_ready, in_mode;
  logic [N-1:0]     in_x, in_y, in_z;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_mode;
  logic [N-1:0]     out_x, out_y, out_z;
  logic [TAG_W-1:0] out_tag;

  cordic_pipe #(.N(N), .FRAC(FRAC), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_mode(out_mode), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  tot, bad;
  real gain_a;

  typedef struct {
    string        nm;
    bit           mode;
    logic [N-1:0] x, y, z;
    real          ex, ey, ez;   // expected outputs of the default build
    bit   [2:0]   chk;          // bit0 x, bit1 y, bit2 z
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    bit               mode;
    real              ex, ey, ez;
  } exp_t;

  exp_t sb[$];

  function automatic real q2r(input logic [N-1:0] v);
    return real'($signed(v)) / SCALE;
  endfunction

  function automatic logic [N-1:0] r2q(input real r);
    return N'(longint'(r * SCALE));
  endfunction

  function automatic real clampv(input real v);
    real mx, mn;
    mx = 4.0 - 1.0 / SCALE;
    mn = -4.0;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic real urand_pm(input real a);
    return (real'($urandom_range(0, 2000000)) / 1000000.0 - 1.0) * a;
  endfunction

  function automatic vec_t mk(input string nm, input bit m, input logic [N-1:0] x,
                              input logic [N-1:0] y, input logic [N-1:0] z,
                              input real ex, input real ey, input real ez, input bit [2:0] c);
    vec_t v;
    v.nm = nm; v.mode = m; v.x = x; v.y = y; v.z = z;
    v.ex = ex; v.ey = ey; v.ez = ez; v.chk = c;
    return v;
  endfunction

  // Ideal math: rotate the vector, or take its length and angle; then the
  // CORDIC gain, output clamp and optional K scaling.
  task automatic model(input bit m, input real x, input real y, input real z,
                       output real ex, output real ey, output real ez);
    if (!m) begin
      ex = x * $cos(z) - y * $sin(z);
      ey = x * $sin(z) + y * $cos(z);
      ez = 0.0;
    end else begin
      ex = $sqrt(x * x + y * y);
      ey = 0.0;
      ez = $atan2(y, x);
    end
    ex = clampv(clampv(ex * gain_a) * KC);
    ey = clampv(clampv(ey * gain_a) * KC);
  endtask

  task automatic chk_val(input string nm, input logic [N-1:0] act, input real e,
                         input real tol, input bit ang);
    real d;
    d = q2r(act) - e;
    if (ang) begin
      while (d > PI)  d = d - 2.0 * PI;
      while (d < -PI) d = d + 2.0 * PI;
    end
    tot++;
    if (d > tol || d < -tol) begin
      bad++;
      $display("FAIL %s got=%f want=%f", nm, q2r(act), e);
    end
  endtask

  task automatic chk_int(input string nm, input longint act, input longint e);
    tot++;
    if (act != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, e);
    end
  endtask

  // Push one sample into an idle pipe and time its emergence.
  task automatic run_one(input bit m, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] z, input logic [TAG_W-1:0] tg,
                         output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_x = x; in_y = y; in_z = z; in_tag = tg;
    out_ready = 1'b1;
    #1;
    chk_int("accept_ready", int'(in_ready), 1);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
  endtask

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, sent, got, cyc, ghost;
    bit  pend, stall, m;
    logic [N-1:0] rx, ry, rz, sx, sy, sz;
    logic [TAG_W-1:0] stag;
    bit  smode;
    real ex, ey, ez;
    exp_t e;

    tot = 0; bad = 0;
    gain_a = 1.0;
    for (int i = 0; i < STAGES; i++) gain_a = gain_a * $sqrt(1.0 + 2.0 ** (-2 * i));

    tbl[0]  = mk("rot_pi6",     0, 32'h136E9DB3, 32'h0,        32'h10C15238,  0.8660254,  0.5,        0.0,        3'b111);
    tbl[1]  = mk("rot_3pi4",    0, 32'h136E9DB3, 32'h0,        32'h4B65F1FD, -0.7071068,  0.7071068,  0.0,        3'b111);
    tbl[2]  = mk("rot_m3pi4",   0, 32'h136E9DB3, 32'h0,        32'hB49A0E03, -0.7071068, -0.7071068,  0.0,        3'b111);
    tbl[3]  = mk("rot_pi2",     0, 32'h136E9DB3, 32'h0,        32'h3243F6A9,  0.0,        1.0,        0.0,        3'b111);
    tbl[4]  = mk("rot_mpi",     0, 32'h136E9DB3, 32'h0,        32'h9B7812AF, -1.0,        0.0,        0.0,        3'b111);
    tbl[5]  = mk("rot_zero",    0, 32'h136E9DB3, 32'h0,        32'h0,         1.0,        0.0,        0.0,        3'b111);
    tbl[6]  = mk("vec_q2",      1, 32'hF0000000, 32'h10000000, 32'h0,         1.1644354,  0.0,        2.3561945,  3'b111);
    tbl[7]  = mk("vec_q4",      1, 32'h10000000, 32'hF0000000, 32'h0,         1.1644354,  0.0,       -0.7853982,  3'b111);
    tbl[8]  = mk("vec_q3",      1, 32'hF0000000, 32'hF0000000, 32'h0,         1.1644354,  0.0,       -2.3561945,  3'b111);
    tbl[9]  = mk("vec_sat",     1, 32'h50000000, 32'h50000000, 32'h0,         4.0 - 1.0 / SCALE, 0.0, 0.7853982, 3'b101);
    tbl[10] = mk("vec_yaxis",   1, 32'h0,        32'h10000000, 32'h0,         0.8233801,  0.0,        1.5707963,  3'b111);

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    in_tag = '0; out_ready = 1'b1;
    #12;
    chk_int("reset_valid", int'(out_valid), 0);
    chk_int("reset_data", longint'({out_x, out_y, out_z} != '0 || out_tag != '0 || out_mode), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_int("reset_ready", int'(in_ready), 1);

    // Directed table, one sample at a time.
    for (int i = 0; i < 11; i++) begin
      run_one(tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].z, TAG_W'(i), lat);
      chk_int({tbl[i].nm, "_lat"}, lat, LAT);
      chk_int({tbl[i].nm, "_tag"}, int'(out_tag), i % 16);
      chk_int({tbl[i].nm, "_mode"}, int'(out_mode), int'(tbl[i].mode));
      if (tbl[i].chk[0]) chk_val({tbl[i].nm, "_x"}, out_x, clampv(tbl[i].ex * KC), VT, 0);
      if (tbl[i].chk[1]) chk_val({tbl[i].nm, "_y"}, out_y, clampv(tbl[i].ey * KC), VT, 0);
      if (tbl[i].chk[2]) chk_val({tbl[i].nm, "_z"}, out_z, tbl[i].ez, AT, 1);
    end

    // Random stream with bubbles and random backpressure.
    sent = 0; got = 0; cyc = 0; pend = 0; stall = 0;
    sx = '0; sy = '0; sz = '0; stag = '0; smode = 0;
    while (got < NS && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk_int("stall_valid", int'(out_valid), 1);
        chk_int("stall_hold", longint'({out_x, out_y, out_z, out_tag, out_mode} ==
                                       {sx, sy, sz, stag, smode}), 1);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (!pend && sent < NS && $urandom_range(0, 3) != 0) begin
        m = bit'($urandom_range(0, 1));
        do begin
          ex = urand_pm(0.6);
          ey = urand_pm(0.6);
        end while (m && $sqrt(ex * ex + ey * ey) < 0.25);
        rx = r2q(ex); ry = r2q(ey); rz = r2q(urand_pm(PI * 0.999));
        in_mode = m; in_x = rx; in_y = ry; in_z = rz; in_tag = TAG_W'(sent % 16);
        pend = 1;
      end
      in_valid = pend;
      #1;
      if (in_valid && in_ready) begin
        e.tag = in_tag; e.mode = in_mode;
        model(in_mode, q2r(in_x), q2r(in_y), q2r(in_z), e.ex, e.ey, e.ez);
        sb.push_back(e);
        sent++;
        pend = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_int("stream_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk_int("stream_tag", int'(out_tag), int'(e.tag));
          chk_int("stream_mode", int'(out_mode), int'(e.mode));
          chk_val("stream_x", out_x, e.ex, VT, 0);
          chk_val("stream_y", out_y, e.ey, VT, 0);
          chk_val("stream_z", out_z, e.ez, AT, 1);
        end
        got++;
      end
      stall = out_valid && !out_ready;
      sx = out_x; sy = out_y; sz = out_z; stag = out_tag; smode = out_mode;
    end
    in_valid = 1'b0;
    chk_int("stream_count", got, NS);
    chk_int("stream_leftover", sb.size(), 0);

    // Fill the pipe, then reset for one cycle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; in_mode = bit'(i % 2);
      in_x = r2q(0.3); in_y = r2q(0.2); in_z = r2q(0.5); in_tag = TAG_W'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_int("midrst_valid", int'(out_valid), 0);
    chk_int("midrst_data", longint'({out_x, out_y, out_z} != '0 || out_tag != '0 || out_mode), 0);
    @(negedge clk);
    rst = 1'b0;
    ghost = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    chk_int("midrst_ghost", ghost, 0);
    run_one(tbl[0].mode, tbl[0].x, tbl[0].y, tbl[0].z, 4'd9, lat);
    chk_int("midrst_lat", lat, LAT);
    chk_int("midrst_tag", int'(out_tag), 9);
    chk_val("midrst_x", out_x, clampv(tbl[0].ex * KC), VT, 0);
    chk_val("midrst_y", out_y, clampv(tbl[0].ey * KC), VT, 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
